sc_stream_ctrl: RTL and testbench
=================================

SC_STREAM_CTRL -- requirements
Module: sc_stream_ctrl

Interface
REQ-001 Parameter N, default 8, sets the generator value width; full stream length is 2^N.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  job request valid.
REQ-005 req_ready  out  1  controller can accept a job.
REQ-006 req_k  in  N  value to encode for this job.
REQ-007 req_seed  in  N  LFSR seed for this job.
REQ-008 req_len  in  N+1  stream length in bits; 0 means 2^N; values above 2^N are clamped to 2^N.
REQ-009 abort  in  1  cancel the job in progress.
REQ-010 gen_load  out  1  load strobe to the bitstream generator.
REQ-011 gen_enable  out  1  advance strobe to the generator.
REQ-012 gen_k  out  N  captured k, driven to the generator.
REQ-013 gen_seed  out  N  captured seed, driven to the generator.
REQ-014 gen_x  in  1  stochastic bit from the generator.
REQ-015 bit_valid  out  1  qualifies bit_out.
REQ-016 bit_out  out  1  stream bit forwarded downstream.
REQ-017 busy  out  1  a job is in LOAD or RUN.
REQ-018 done  out  1  one-cycle job-complete pulse.
REQ-019 ones_cnt  out  N+1  number of 1s emitted by the last completed job.

Function
REQ-020 The controller SHALL be a 4-state FSM: IDLE, LOAD, RUN, DONE.
REQ-021 In IDLE, req_ready = 1; in all other states, and while rst_n = 0, req_ready = 0.
REQ-022 When req_valid & req_ready at a clock edge: capture k, seed and the effective length; clear ones_cnt and the bit counter; go to LOAD.
REQ-023 LOAD lasts exactly one cycle with gen_load = 1 and gen_enable = 0; it then goes to RUN.
REQ-024 gen_k and gen_seed SHALL hold the captured values from capture until the next capture.
REQ-025 In RUN, each cycle: gen_enable = 1, bit_valid = 1, bit_out = gen_x; the bit counter increments; ones_cnt increments when gen_x = 1.
REQ-026 RUN SHALL last exactly the effective length in cycles; after the last bit it goes to DONE.
REQ-027 DONE lasts one cycle with done = 1, then goes to IDLE; ones_cnt holds its value until the next capture.
REQ-028 Latency: capture edge to done-high cycle = length + 2 cycles; back-to-back jobs SHALL have one IDLE cycle between done and the next LOAD.
REQ-029 busy = 1 in LOAD and RUN only; bit_valid, gen_enable and gen_load SHALL be 0 outside the states that assert them.
REQ-030 abort high in LOAD or RUN: next state IDLE, no done pulse, ones_cnt holds its partial count; abort has priority over completion of the last bit.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 Counters SHALL be N+1 bits wide, so length 2^N never wraps.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE; counters, captured registers and ones_cnt to 0; and all outputs to 0 (including req_ready), regardless of the current state.
REQ-034 After rst_n deasserts, the first job SHALL be accepted at the next edge where req_valid = 1.

Configuration
REQ-035 Macro SC_ONES_COUNT_EN defined: the ones counter is implemented as specified above.
REQ-036 Macro SC_ONES_COUNT_EN undefined: no ones counter is built; ones_cnt is constant 0; all other behaviour is unchanged.

Verification (N=8, generator model attached)
REQ-037 k=64, seed=0x01, len=0 -> bit_valid high for exactly 256 consecutive cycles; done on cycle 258 after capture; ones_cnt equals the bench's count of bit_out ones.
REQ-038 k=0, len=16 -> 16 valid bits, all 0; ones_cnt=0. Then k=255, seed=0xFF, len=16 -> ones_cnt matches the model.
REQ-039 req_valid held high through a job -> exactly one capture per job; second LOAD occurs 2 cycles after the first done.
REQ-040 abort asserted in the 5th RUN cycle -> gen_enable=0 next cycle; no done; req_ready=1 next cycle; ones_cnt holds the count of the 5 emitted bits.
REQ-041 rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; new job after release completes normally.
REQ-042 SC_ONES_COUNT_EN undefined, k=128, len=0 -> ones_cnt stays 0; timing is identical to REQ-037.

Source files
------------

// File: rtl/sc_stream_ctrl.sv
// Stream controller: captures a job, drives a stochastic bitstream generator for the
// requested length and forwards its bits. Optional ones counter: define SC_ONES_COUNT_EN.
module sc_stream_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_k,
    input  logic [N-1:0] req_seed,
    input  logic [N:0]   req_len,
    input  logic         abort,
    output logic         gen_load,
    output logic         gen_enable,
    output logic [N-1:0] gen_k,
    output logic [N-1:0] gen_seed,
    input  logic         gen_x,
    output logic         bit_valid,
    output logic         bit_out,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [N:0] FULL_LEN = {1'b1, {N{1'b0}}};
    localparam logic [N:0] ONE      = {{N{1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] k_q, seed_q;
    logic [N:0]   len_q, cnt_q;
    logic [N:0]   eff_len;
    logic         accept;
    logic         last_bit;

    // Zero and oversize lengths both collapse to the full 2^N stream.
    assign eff_len  = (req_len == '0 || req_len > FULL_LEN) ? FULL_LEN : req_len;
    assign accept   = (state_q == IDLE) && req_valid;
    assign last_bit = (cnt_q + ONE) == len_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = LOAD;
            LOAD:    state_d = abort ? IDLE : RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            seed_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q    <= req_k;
                seed_q <= req_seed;
                len_q  <= eff_len;
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

`ifdef SC_ONES_COUNT_EN
    logic [N:0] ones_q;

    // Keeps counting the bit of an aborting RUN cycle, so a partial count stays exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if (accept) begin
            ones_q <= '0;
        end else if (state_q == RUN && gen_x) begin
            ones_q <= ones_q + ONE;
        end
    end

    assign ones_cnt = ones_q;
`else
    assign ones_cnt = '0;
`endif

    // req_ready is gated by rst_n so it reads 0 while reset is held.
    assign req_ready  = rst_n && (state_q == IDLE);
    assign gen_load   = (state_q == LOAD);
    assign gen_enable = (state_q == RUN);
    assign bit_valid  = (state_q == RUN);
    assign bit_out    = (state_q == RUN) && gen_x;
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign gen_k      = k_q;
    assign gen_seed   = seed_q;

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// Self-checking bench for sc_stream_ctrl (N=8) with a behavioural LFSR comparator generator.
module tb_sc_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_k;
    logic [7:0] req_seed;
    logic [8:0] req_len;
    logic       abort;
    logic       gen_load;
    logic       gen_enable;
    logic [7:0] gen_k;
    logic [7:0] gen_seed;
    logic       gen_x;
    logic       bit_valid;
    logic       bit_out;
    logic       busy;
    logic       done;
    logic [8:0] ones_cnt;

    int tests  = 0;
    int failed = 0;

    logic [7:0] lfsr = 8'h00;

    sc_stream_ctrl #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_k(req_k), .req_seed(req_seed), .req_len(req_len), .abort(abort),
        .gen_load(gen_load), .gen_enable(gen_enable), .gen_k(gen_k), .gen_seed(gen_seed),
        .gen_x(gen_x), .bit_valid(bit_valid), .bit_out(bit_out), .busy(busy),
        .done(done), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsrNext(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Generator: reload on gen_load, step on gen_enable, emit 1 when state < k.
    always @(posedge clk) begin
        if (gen_load) lfsr <= gen_seed;
        else if (gen_enable) lfsr <= lfsrNext(lfsr);
    end
    assign gen_x = (lfsr < gen_k);

    function automatic int modelOnes(input logic [7:0] k, input logic [7:0] seed, input int len);
        logic [7:0] l = seed;
        int n = 0;
        for (int i = 0; i < len; i++) begin
            if (l < k) n++;
            l = lfsrNext(l);
        end
        return n;
    endfunction

    function automatic int expCount(input int ones);
`ifdef SC_ONES_COUNT_EN
        return ones;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] k, input logic [7:0] seed, input logic [8:0] len);
        @(negedge clk);
        req_k     = k;
        req_seed  = seed;
        req_len   = len;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic runJob(input logic [7:0] k, input logic [7:0] seed, input logic [8:0] len,
                          input int expBits, input int expDone, input string tag);
        int bits = 0, ones = 0, doneCycle = -1, bad = 0, expOnes;
        expOnes = modelOnes(k, seed, expBits);
        applyStimulus(k, seed, len);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput({tag, "_load"}, {28'd0, gen_load, gen_enable, busy, req_ready}, 4'b1010);
        checkOutput({tag, "_captured"}, {gen_k, gen_seed}, {k, seed});
        for (int c = 2; c <= expBits + 12 && doneCycle < 0; c++) begin
            @(negedge clk);
            if (bit_valid) begin
                bits++;
                if (bit_out !== gen_x || gen_enable !== 1'b1 || c != bits + 1) bad++;
                if (bit_out) ones++;
            end
            if (done) doneCycle = c;
        end
        checkOutput({tag, "_bits"}, bits, expBits);
        checkOutput({tag, "_done_cycle"}, doneCycle, expDone);
        checkOutput({tag, "_stream"}, bad, 0);
        checkOutput({tag, "_bench_ones"}, ones, expOnes);
        checkOutput({tag, "_ones_cnt"}, ones_cnt, expCount(ones));
        @(negedge clk);
        checkOutput({tag, "_idle"}, {29'd0, req_ready, busy, done}, 3'b100);
        checkOutput({tag, "_ones_hold"}, ones_cnt, expCount(ones));
    endtask

    typedef struct {
        logic [7:0] k;
        logic [7:0] seed;
        logic [8:0] len;
        int         expBits;
        int         expDone;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int loads, secondLoad, firstDone, doneSeen, partial;

        vecs[0] = '{k: 8'd64,  seed: 8'h01, len: 9'd0,   expBits: 256, expDone: 258};
        vecs[1] = '{k: 8'd0,   seed: 8'h5A, len: 9'd16,  expBits: 16,  expDone: 18};
        vecs[2] = '{k: 8'd255, seed: 8'hFF, len: 9'd16,  expBits: 16,  expDone: 18};
        vecs[3] = '{k: 8'd128, seed: 8'h3C, len: 9'd1,   expBits: 1,   expDone: 3};
        vecs[4] = '{k: 8'd100, seed: 8'h11, len: 9'd300, expBits: 256, expDone: 258};
        vecs[5] = '{k: 8'd200, seed: 8'h80, len: 9'd255, expBits: 255, expDone: 257};
        vecs[6] = '{k: 8'd128, seed: 8'h3C, len: 9'd0,   expBits: 256, expDone: 258};

        rst_n = 1'b0; req_valid = 1'b0; req_k = '0; req_seed = '0; req_len = '0; abort = 1'b0;
        #12;
        checkOutput("reset_flags",
                    {25'd0, req_ready, gen_load, gen_enable, bit_valid, bit_out, busy, done},
                    0);
        checkOutput("reset_regs", {gen_k, gen_seed, ones_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            runJob(vecs[i].k, vecs[i].seed, vecs[i].len, vecs[i].expBits, vecs[i].expDone,
                   $sformatf("vec%0d", i));

        // Request held high: one capture per job, second LOAD two cycles after done.
        loads = 0; secondLoad = -1; firstDone = -1;
        applyStimulus(8'd200, 8'h55, 9'd4);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (gen_load) begin
                loads++;
                if (loads == 2) secondLoad = c;
            end
            if (done && firstDone < 0) firstDone = c;
        end
        req_valid = 1'b0;
        checkOutput("b2b_first_done", firstDone, 6);
        checkOutput("b2b_second_load", secondLoad, 8);
        checkOutput("b2b_load_count", loads, 2);
        doneSeen = 0;
        for (int c = 0; c < 20 && doneSeen == 0; c++) begin
            @(negedge clk);
            if (done) doneSeen = 1;
        end
        checkOutput("b2b_second_done", doneSeen, 1);

        // Abort during the 5th RUN cycle.
        partial = modelOnes(8'd128, 8'h3C, 5);
        applyStimulus(8'd128, 8'h3C, 9'd20);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_run_valid", bit_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_next", {29'd0, gen_enable, req_ready, busy}, 3'b010);
        checkOutput("abort_partial", ones_cnt, expCount(partial));
        doneSeen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) doneSeen = 1;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_hold", ones_cnt, expCount(partial));

        abort = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_idle_ignored", {29'd0, req_ready, busy, gen_load}, 3'b100);
        checkOutput("abort_idle_ones", ones_cnt, expCount(partial));
        abort = 1'b0;

        // Asynchronous reset in the middle of RUN, then a fresh job.
        applyStimulus(8'd64, 8'h01, 9'd50);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_flags",
                    {25'd0, req_ready, gen_load, gen_enable, bit_valid, bit_out, busy, done},
                    0);
        checkOutput("midrst_regs", {gen_k, gen_seed, ones_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        runJob(8'd64, 8'h01, 9'd0, 256, 258, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
